// File: rtl/router_egress_reader_if.sv
// Signal bundle between the egress reader, its packet FIFO and the downstream port.
// master: the reader side. slave: the FIFO/downstream environment side.
interface router_egress_reader_if;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_read_enb;
   logic       fifo_soft_reset;
   logic [7:0] dout;
   logic       dout_vld;
   logic       dout_rdy;
   logic       dout_last;
   logic       pkt_done;
   logic       parity_err;

   modport master (
      input  fifo_empty, fifo_data, dout_rdy,
      output fifo_read_enb, fifo_soft_reset, dout, dout_vld, dout_last, pkt_done, parity_err
   );

   modport slave (
      output fifo_empty, fifo_data, dout_rdy,
      input  fifo_read_enb, fifo_soft_reset, dout, dout_vld, dout_last, pkt_done, parity_err
   );
endinterface

// File: rtl/router_egress_reader.sv
// Egress reader for one router packet FIFO: pops one byte at a time, presents it downstream
// with valid/ready, frames packets from the header length field, checks the parity byte and
// flushes the FIFO when downstream stalls for TIMEOUT cycles.
module router_egress_reader #(
   parameter int unsigned TIMEOUT = 30
) (
   input  logic                  clk,
   input  logic                  reset,
   router_egress_reader_if.master bus
);

   typedef enum logic [1:0] {StIdle, StWait, StSend, StDrop} state_t;

   localparam logic [7:0] StallMax = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] dout_r;
   logic [7:0] stall_cnt;
   logic [7:0] par;
   logic [6:0] rem;
   logic       in_pkt;
   logic       dout_vld_r;
   logic       soft_reset_r;
   logic       pkt_done_r;
   logic       parity_err_r;
   logic       pop;

   // Pop only from IDLE with data available; gated by reset so nothing is popped while held.
   assign pop = (state == StIdle) && !bus.fifo_empty && !reset;

   // Main FSM: byte transfer, framing, stall timeout and registered pulse outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= StIdle;
         dout_r       <= 8'd0;
         stall_cnt    <= 8'd0;
         par          <= 8'd0;
         rem          <= 7'd0;
         in_pkt       <= 1'b0;
         dout_vld_r   <= 1'b0;
         soft_reset_r <= 1'b0;
         pkt_done_r   <= 1'b0;
         parity_err_r <= 1'b0;
      end else begin
         pkt_done_r   <= 1'b0;
         parity_err_r <= 1'b0;
         soft_reset_r <= 1'b0;
         unique case (state)
            StIdle: begin
               if (pop) begin
                  state <= StWait;
               end
            end
            StWait: begin
               // FIFO data is registered, so it is valid in this cycle.
               dout_r     <= bus.fifo_data;
               dout_vld_r <= 1'b1;
               stall_cnt  <= 8'd0;
               state      <= StSend;
            end
            StSend: begin
               // Acceptance has priority over the timeout in the same cycle.
               if (bus.dout_rdy) begin
                  dout_vld_r <= 1'b0;
                  state      <= StIdle;
                  if (!in_pkt) begin
                     in_pkt <= 1'b1;
                     rem    <= {1'b0, dout_r[7:2]} + 7'd1;
                     par    <= dout_r;
                  end else if (rem == 7'd1) begin
                     pkt_done_r   <= 1'b1;
                     parity_err_r <= (par != dout_r);
                     in_pkt       <= 1'b0;
                     rem          <= 7'd0;
                  end else begin
                     par <= par ^ dout_r;
                     rem <= rem - 7'd1;
                  end
               end else if (stall_cnt == StallMax) begin
                  dout_vld_r   <= 1'b0;
                  soft_reset_r <= 1'b1;
                  state        <= StDrop;
               end else begin
                  stall_cnt <= stall_cnt + 8'd1;
               end
            end
            StDrop: begin
               // FIFO is flushed this cycle; the next byte read starts a fresh packet.
               in_pkt    <= 1'b0;
               rem       <= 7'd0;
               par       <= 8'd0;
               stall_cnt <= 8'd0;
               state     <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   assign bus.fifo_read_enb   = pop;
   assign bus.fifo_soft_reset = soft_reset_r;
   assign bus.dout            = dout_r;
   assign bus.dout_vld        = dout_vld_r;
   assign bus.dout_last       = dout_vld_r & in_pkt & (rem == 7'd1);
   assign bus.pkt_done        = pkt_done_r;
   assign bus.parity_err      = parity_err_r;

endmodule

// File: tb/tb_router_egress_reader.sv
// Bench for router_egress_reader: packet table, reset/timeout/tie sequences and a randomized
// backpressure run checked against a packet-level reference model.
module tb_router_egress_reader;

   localparam int unsigned TO = 30;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   router_egress_reader_if bus ();

   router_egress_reader #(.TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Packet FIFO model: bench writes wr_ptr, this block owns rd_ptr.
   logic [7:0] mem [0:4095];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int pop_cnt = 0;

   assign bus.fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (bus.fifo_soft_reset) begin
         rd_ptr <= wr_ptr;
      end else if (bus.fifo_read_enb && (wr_ptr != rd_ptr)) begin
         bus.fifo_data <= mem[rd_ptr[11:0]];
         rd_ptr        <= rd_ptr + 1;
         pop_cnt       <= pop_cnt + 1;
      end
   end

   int n_tests = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[11:0]] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic check_zero_outs(input string tag);
      check({tag, " dout"}, {24'd0, bus.dout}, 0);
      check({tag, " dout_vld"}, {31'd0, bus.dout_vld}, 0);
      check({tag, " dout_last"}, {31'd0, bus.dout_last}, 0);
      check({tag, " pkt_done"}, {31'd0, bus.pkt_done}, 0);
      check({tag, " parity_err"}, {31'd0, bus.parity_err}, 0);
      check({tag, " soft_reset"}, {31'd0, bus.fifo_soft_reset}, 0);
      check({tag, " read_enb"}, {31'd0, bus.fifo_read_enb}, 0);
   endtask

   task automatic wait_vld(input string tag);
      int c = 0;
      while (!bus.dout_vld && c < 20) begin
         @(negedge clk);
         c++;
      end
      check({tag, " vld wait"}, {31'd0, bus.dout_vld}, 1);
   endtask

   typedef struct {
      logic [5:0][7:0] bytes;
      int              n;
      logic            err;
   } vec_t;

   function automatic vec_t mk(input logic [47:0] b, input int n, input logic err);
      vec_t v;
      v.bytes = b;
      v.n     = n;
      v.err   = err;
      return v;
   endfunction

   // Called at a negedge with the DUT idle; dout_rdy held high for the whole packet.
   task automatic run_vec(input vec_t v, input string tag, input bit do_push);
      int acc = 0;
      int cyc = 0;
      int done_cnt = 0;
      int err_cnt = 0;
      int done_cyc = -1;
      int acc_cyc [6];
      for (int i = 0; i < 6; i++) acc_cyc[i] = 0;
      bus.dout_rdy = 1'b1;
      if (do_push) begin
         for (int i = 0; i < v.n; i++) push(v.bytes[i]);
      end
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (bus.fifo_soft_reset) check({tag, " soft_reset"}, 1, 0);
         if (bus.pkt_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (bus.parity_err) err_cnt++;
         end else if (bus.parity_err) begin
            err_cnt += 100;
         end
         if (bus.dout_vld && bus.dout_rdy) begin
            if (acc < v.n) begin
               check($sformatf("%s byte%0d", tag, acc), {24'd0, bus.dout}, {24'd0, v.bytes[acc]});
               check($sformatf("%s last%0d", tag, acc), {31'd0, bus.dout_last},
                     (acc == v.n - 1) ? 1 : 0);
               acc_cyc[acc] = cyc;
            end
            acc++;
         end
         if (acc >= v.n && done_cyc >= 0 && cyc >= done_cyc + 2) break;
      end
      check({tag, " count"}, acc, v.n);
      check({tag, " latency"}, acc_cyc[0], 2);
      check({tag, " pkt_done"}, done_cnt, 1);
      check({tag, " parity_err"}, err_cnt, {31'd0, v.err});
      check({tag, " done timing"}, done_cyc, acc_cyc[v.n - 1] + 1);
      for (int i = 1; i < v.n; i++) begin
         check($sformatf("%s spacing%0d", tag, i), acc_cyc[i] - acc_cyc[i - 1], 3);
      end
   endtask

   vec_t vecs [6];

   // Random-run state
   logic [7:0] exp_b [$];
   bit         exp_l [$];
   bit         exp_e [$];
   int unsigned rl;
   logic [7:0] rb;
   logic [7:0] rpar;
   logic [7:0] rhdr;
   bit         rbad;
   int         idx;
   int         pend;
   int         pkt_i;
   int         zero_run;
   int         vld_cyc;
   int         sr_cnt;
   int         p0;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.dout_rdy = 1'b0;
      vecs[0] = mk(48'h0000_903C_A509, 4, 1'b0);
      vecs[1] = mk(48'h0000_913C_A509, 4, 1'b1);
      vecs[2] = mk(48'h0000_0000_0202, 2, 1'b0);
      vecs[3] = mk(48'h0000_00FB_FF04, 3, 1'b0);
      vecs[4] = mk(48'h007F_5634_120F, 5, 1'b0);
      vecs[5] = mk(48'h0000_0000_0003, 2, 1'b1);

      // Reset state
      repeat (3) @(negedge clk);
      check_zero_outs("por");
      reset = 1'b0;
      @(negedge clk);
      check("idle empty read_enb", {31'd0, bus.fifo_read_enb}, 0);

      // Async reset mid-packet with the FIFO non-empty
      bus.dout_rdy = 1'b1;
      push(8'h09);
      wait_vld("rst hdr");
      check("rst hdr dout", {24'd0, bus.dout}, 32'h09);
      @(negedge clk);
      bus.dout_rdy = 1'b0;
      push(8'hA5);
      push(8'h02);
      wait_vld("rst pay");
      check("rst pay dout", {24'd0, bus.dout}, 32'hA5);
      check("rst pay last", {31'd0, bus.dout_last}, 0);
      #2;
      reset = 1'b1;
      #1;
      check_zero_outs("async rst");
      p0 = pop_cnt;
      repeat (2) @(negedge clk);
      check("no pop in reset", pop_cnt, p0);
      check("read_enb in reset", {31'd0, bus.fifo_read_enb}, 0);
      reset = 1'b0;
      #1;
      check("first pop after release", {31'd0, bus.fifo_read_enb}, 1);
      bus.dout_rdy = 1'b1;
      push(8'h02);
      run_vec(mk(48'h0202, 2, 1'b0), "post-rst", 1'b0);

      // Packet table
      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);

      // Timeout: stall on the first payload byte of a 0x0D packet
      bus.dout_rdy = 1'b1;
      push(8'h0D);
      push(8'h11);
      push(8'h22);
      wait_vld("to hdr");
      check("to hdr dout", {24'd0, bus.dout}, 32'h0D);
      @(negedge clk);
      bus.dout_rdy = 1'b0;
      vld_cyc = 0;
      sr_cnt = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (bus.dout_vld) begin
            vld_cyc++;
            if (bus.dout != 8'h11) check("to stalled dout", {24'd0, bus.dout}, 32'h11);
         end
         if (bus.fifo_soft_reset) begin
            sr_cnt++;
            check("to vld cycles", vld_cyc, TO);
            check("to vld in drop", {31'd0, bus.dout_vld}, 0);
         end else if (sr_cnt > 0) begin
            break;
         end
      end
      check("to soft_reset pulses", sr_cnt, 1);
      check("to flushed read_enb", {31'd0, bus.fifo_read_enb}, 0);
      run_vec(mk(48'h0202, 2, 1'b0), "after drop", 1'b1);

      // Tie: ready arrives in the last allowed stall cycle
      bus.dout_rdy = 1'b0;
      push(8'h02);
      vld_cyc = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (bus.dout_vld) vld_cyc++;
         if (vld_cyc == TO) begin
            bus.dout_rdy = 1'b1;
            break;
         end
      end
      check("tie stall cycles", vld_cyc, TO);
      sr_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.fifo_soft_reset) sr_cnt++;
      end
      check("tie no soft_reset", sr_cnt, 0);
      check("tie accepted", {31'd0, bus.dout_vld}, 0);
      run_vec(mk(48'h02, 1, 1'b0), "tie parity", 1'b1);

      // Randomized backpressure against a packet-level model
      for (int p = 0; p < 12; p++) begin
         rl = $urandom_range(0, 12);
         rhdr = {6'(rl), 2'($urandom_range(0, 3))};
         rpar = rhdr;
         push(rhdr);
         exp_b.push_back(rhdr);
         exp_l.push_back(1'b0);
         for (int k = 0; k < int'(rl); k++) begin
            rb = 8'($urandom);
            rpar = rpar ^ rb;
            push(rb);
            exp_b.push_back(rb);
            exp_l.push_back(1'b0);
         end
         rbad = ($urandom_range(0, 3) == 0);
         if (rbad) rpar = rpar ^ (8'h01 << $urandom_range(0, 7));
         push(rpar);
         exp_b.push_back(rpar);
         exp_l.push_back(1'b1);
         exp_e.push_back(rbad);
      end
      idx = 0;
      pend = 0;
      pkt_i = 0;
      zero_run = 0;
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         check("rand pkt_done", {31'd0, bus.pkt_done}, (pend != 0) ? 1 : 0);
         check("rand parity_err", {31'd0, bus.parity_err}, (pend == 2) ? 1 : 0);
         pend = 0;
         if (bus.fifo_soft_reset) check("rand soft_reset", 1, 0);
         if (bus.fifo_read_enb && bus.dout_vld) check("rand pop while valid", 1, 0);
         if (zero_run >= 20) bus.dout_rdy = 1'b1;
         else bus.dout_rdy = 1'($urandom);
         zero_run = bus.dout_rdy ? 0 : zero_run + 1;
         if (bus.dout_vld) begin
            if (idx < exp_b.size()) begin
               check($sformatf("rand byte%0d", idx), {24'd0, bus.dout}, {24'd0, exp_b[idx]});
               check($sformatf("rand last%0d", idx), {31'd0, bus.dout_last}, {31'd0, exp_l[idx]});
               if (bus.dout_rdy) begin
                  if (exp_l[idx]) begin
                     pend = exp_e[pkt_i] ? 2 : 1;
                     pkt_i++;
                  end
                  idx++;
               end
            end else begin
               check("rand extra byte", 1, 0);
            end
         end
         if (idx == exp_b.size() && pend == 0) break;
      end
      check("rand bytes delivered", idx, exp_b.size());
      check("rand packets done", pkt_i, exp_e.size());

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
